// File: rtl/ccard_i2c_pkg.sv
// Shared types and constants for the control-card I2C responder.
package ccard_i2c_pkg;

  localparam int unsigned NREG_MAX = 16;
  localparam int unsigned PtrW     = $clog2(NREG_MAX);

  // SDA bit values seen on the bus during the acknowledge slot.
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StRdataAck,
    StWait
  } state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// 2-FF synchronizer, optional glitch filter and edge detect for one I2C line.
// Glitch filter enabled by defining CCARD_I2C_SLV_GLITCH_FILT_EN.
module i2c_line_filter
`ifdef CCARD_I2C_SLV_GLITCH_FILT_EN
#(
  parameter int unsigned FILT_LEN = 3
)
`endif
(
  input  logic clk10M,
  input  logic rstn,
  input  logic pad,
  output logic line,
  output logic rise,
  output logic fall
);

  logic [1:0] sync_q;
  logic       filt;
  logic       prev_q;

  // Reset to 1 so an idle (pulled-up) bus produces no spurious edges.
  always_ff @(posedge clk10M or negedge rstn) begin
    if (!rstn) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[0], pad};
      prev_q <= filt;
    end
  end

`ifdef CCARD_I2C_SLV_GLITCH_FILT_EN
  localparam int unsigned CntW = $clog2(FILT_LEN + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            filt_q, filt_d;

  // Output follows the input only after FILT_LEN consecutive differing samples.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (sync_q[1] == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntW'(FILT_LEN - 1)) begin
      filt_d = sync_q[1];
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk10M or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  assign filt = sync_q[1];
`endif

  assign line = filt;
  assign rise = filt & ~prev_q;
  assign fall = ~filt & prev_q;

endmodule

// File: rtl/ccard_i2c_slave.sv
// I2C responder register file: pointer-addressed byte writes, sequential reads.
// Optional input glitch filter enabled by defining CCARD_I2C_SLV_GLITCH_FILT_EN.
module ccard_i2c_slave
  import ccard_i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h20,
  parameter int unsigned NREG       = 7
`ifdef CCARD_I2C_SLV_GLITCH_FILT_EN
  , parameter int unsigned FILT_LEN = 3
`endif
) (
  input  logic       clk10M,
  input  logic       rstn,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] reg0,
  output logic [7:0] reg1,
  output logic [7:0] reg2,
  output logic [7:0] reg3,
  output logic [7:0] reg4,
  output logic [7:0] reg5,
  output logic [7:0] reg6,
  output logic       wr_stb,
  output logic [3:0] wr_idx,
  output logic       busy
);

  logic scl, scl_rise, scl_fall;
  logic sda, sda_rise, sda_fall;

  i2c_line_filter
`ifdef CCARD_I2C_SLV_GLITCH_FILT_EN
    #(.FILT_LEN(FILT_LEN))
`endif
  u_scl_filt (
    .clk10M (clk10M),
    .rstn   (rstn),
    .pad    (scl_i),
    .line   (scl),
    .rise   (scl_rise),
    .fall   (scl_fall)
  );

  i2c_line_filter
`ifdef CCARD_I2C_SLV_GLITCH_FILT_EN
    #(.FILT_LEN(FILT_LEN))
`endif
  u_sda_filt (
    .clk10M (clk10M),
    .rstn   (rstn),
    .pad    (sda_i),
    .line   (sda),
    .rise   (sda_rise),
    .fall   (sda_fall)
  );

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic [PtrW-1:0] ptr_q, ptr_d, ptr_inc;
  logic            rw_q, rw_d;
  logic            sda_oe_q, sda_oe_d;
  logic            busy_q, busy_d;
  logic            wr_stb_q;
  logic [3:0]      wr_idx_q;
  logic [7:0]      regs_q [NREG];
  logic [7:0]      rx_byte, rd_cur, rd_nxt;
  logic            reg_we, start, stop, byte_done;

  assign start     = sda_fall & scl;
  assign stop      = sda_rise & scl;
  assign rx_byte   = {shift_q[6:0], sda};
  assign byte_done = scl_rise && (bit_cnt_q == 3'd7);
  assign ptr_inc   = (ptr_q == PtrW'(NREG - 1)) ? '0 : ptr_q + 1'b1;

  always_comb begin
    rd_cur = '0;
    rd_nxt = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (ptr_q == PtrW'(i))   rd_cur = regs_q[i];
      if (ptr_inc == PtrW'(i)) rd_nxt = regs_q[i];
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ptr_d     = ptr_q;
    rw_d      = rw_q;
    sda_oe_d  = sda_oe_q;
    busy_d    = busy_q;
    reg_we    = 1'b0;
    if (start) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
    end else if (stop) begin
      state_d  = StIdle;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        StAddr, StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (byte_done) begin
            if (state_q == StAddr) begin
              if (rx_byte[7:1] == SLAVE_ADDR) begin
                state_d = StAddrAck;
                rw_d    = rx_byte[0];
                if (rx_byte[0]) shift_d = rd_cur;
              end else begin
                state_d = StWait;
              end
            end else if (state_q == StPtr) begin
              if (rx_byte < 8'(NREG)) begin
                ptr_d   = rx_byte[PtrW-1:0];
                state_d = StPtrAck;
              end else begin
                state_d = StWait;
              end
            end else begin
              reg_we  = 1'b1;
              ptr_d   = ptr_inc;
              state_d = StWdataAck;
            end
          end
        end
        // First scl_fall starts the ACK drive, the second one ends it.
        StAddrAck, StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = ~ACK;
            end else begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = '0;
              if (state_q == StAddrAck && rw_q) begin
                sda_oe_d = ~shift_q[7];
                shift_d  = {shift_q[6:0], 1'b0};
                state_d  = StRdata;
              end else if (state_q == StAddrAck) begin
                state_d = StPtr;
              end else begin
                state_d = StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (scl_fall) begin
            sda_oe_d = ~shift_q[7];
            shift_d  = {shift_q[6:0], 1'b0};
          end
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_d = StRdataAck;
          end
        end
        StRdataAck: begin
          if (scl_fall) sda_oe_d = 1'b0;
          if (scl_rise) begin
            if (sda == NACK) begin
              state_d = StWait;
            end else begin
              ptr_d     = ptr_inc;
              shift_d   = rd_nxt;
              bit_cnt_d = '0;
              state_d   = StRdata;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk10M or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      ptr_q     <= '0;
      rw_q      <= 1'b0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      wr_idx_q  <= '0;
      for (int unsigned i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sda_oe_q  <= sda_oe_d;
      busy_q    <= busy_d;
      wr_stb_q  <= reg_we;
      if (reg_we) wr_idx_q <= 4'(ptr_q);
      for (int unsigned i = 0; i < NREG; i++) begin
        if (reg_we && ptr_q == PtrW'(i)) regs_q[i] <= rx_byte;
      end
    end
  end

  logic [7:0] reg_vec [7];

  for (genvar i = 0; i < 7; i++) begin : g_reg
    if (i < NREG) begin : g_on
      assign reg_vec[i] = regs_q[i];
    end else begin : g_off
      assign reg_vec[i] = '0;
    end
  end

  assign reg0   = reg_vec[0];
  assign reg1   = reg_vec[1];
  assign reg2   = reg_vec[2];
  assign reg3   = reg_vec[3];
  assign reg4   = reg_vec[4];
  assign reg5   = reg_vec[5];
  assign reg6   = reg_vec[6];
  assign sda_oe = sda_oe_q;
  assign wr_stb = wr_stb_q;
  assign wr_idx = wr_idx_q;
  assign busy   = busy_q;

endmodule
